// File: rtl/hps_cmd_handshake.sv
// HPS command handshake: synchronises the PIO request toggle, offers the opcode to
// fabric via valid/ready/done with a timeout, and returns a status word plus irq.
module hps_cmd_handshake #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] pio_cmd_in,
  output logic       cmd_valid,
  output logic [3:0] cmd_opcode,
  input  logic       cmd_ready,
  input  logic       cmd_done,
  input  logic       cmd_result,
  output logic       cmd_abort,
  output logic [4:0] pio_status_out,
  output logic       irq
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic                        req_prev_q;
  logic                        req_edge;
  logic [4:0]                  sync_last;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic [3:0] opcode_q, opcode_d;
  logic       abort_q, abort_d;
  logic       ack_q, ack_d;
  logic       busy_q, busy_d;
  logic       err_to_q, err_to_d;
  logic       err_ov_q, err_ov_d;
  logic       result_q, result_d;
  logic       irq_q, irq_d;
  logic       pend_res_q, pend_res_d;
  logic       pend_to_q, pend_to_d;
  logic       done_now;
  logic       expired;

  // Synchroniser: all five bits share one chain so opcode and toggle stay coherent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      req_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pio_cmd_in};
      req_prev_q <= sync_q[SYNC_STAGES-1][4];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign req_edge  = sync_last[4] ^ req_prev_q;
  assign expired   = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Handshake FSM: every output is a register loaded from its _d value.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    opcode_d   = opcode_q;
    abort_d    = 1'b0;
    ack_d      = ack_q;
    busy_d     = busy_q;
    err_to_d   = err_to_q;
    err_ov_d   = err_ov_q;
    result_d   = result_q;
    irq_d      = 1'b0;
    pend_res_d = pend_res_q;
    pend_to_d  = pend_to_q;
    done_now   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_edge) begin
          opcode_d = sync_last[3:0];
          err_to_d = 1'b0;
          err_ov_d = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = '0;
          valid_d  = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        cnt_d    = cnt_q + CNT_W'(1);
        done_now = (state_q == S_ISSUE) ? (cmd_ready & cmd_done) : cmd_done;
        if (req_edge) err_ov_d = 1'b1;
        // Completion in the same cycle as expiry takes precedence over the timeout.
        if (done_now) begin
          pend_res_d = cmd_result;
          pend_to_d  = 1'b0;
          valid_d    = 1'b0;
          state_d    = S_RESP;
        end else if (expired) begin
          pend_res_d = 1'b0;
          pend_to_d  = 1'b1;
          abort_d    = 1'b1;
          valid_d    = 1'b0;
          state_d    = S_RESP;
        end else if (state_q == S_ISSUE && cmd_ready) begin
          valid_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (req_edge) err_ov_d = 1'b1;
        ack_d    = ~ack_q;
        busy_d   = 1'b0;
        result_d = pend_res_q;
        err_to_d = pend_to_q;
        irq_d    = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      opcode_q   <= '0;
      abort_q    <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_to_q   <= 1'b0;
      err_ov_q   <= 1'b0;
      result_q   <= 1'b0;
      irq_q      <= 1'b0;
      pend_res_q <= 1'b0;
      pend_to_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      opcode_q   <= opcode_d;
      abort_q    <= abort_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      err_to_q   <= err_to_d;
      err_ov_q   <= err_ov_d;
      result_q   <= result_d;
      irq_q      <= irq_d;
      pend_res_q <= pend_res_d;
      pend_to_q  <= pend_to_d;
    end
  end

  assign cmd_valid      = valid_q;
  assign cmd_opcode     = opcode_q;
  assign cmd_abort      = abort_q;
  assign irq            = irq_q;
  assign pio_status_out = {ack_q, busy_q, err_to_q, err_ov_q, result_q};

endmodule
